// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: multiplexed common-anode 7-segment display driver.
// An unsigned binary input is converted to BCD by a sequential double-dabble
// engine (IDLE -> SHIFT x BIN_W -> LOAD). The result is committed atomically
// to the display registers, which are scanned one digit per DIV clocks.
// Optional feature macro: FND_LZB_EN enables leading-zero blanking.
module fnd_scan_controller #(
  parameter int N_DIGITS = 4,
  parameter int BIN_W    = 14,
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BIN_W-1:0]    bin,
  input  logic [N_DIGITS-1:0] dp,
  output logic [7:0]          seg,
  output logic [N_DIGITS-1:0] seg_comm,
  output logic                busy
);

  localparam int DIV        = CLK_HZ / SCAN_HZ;
  localparam int CNT_W      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int SH_W       = $clog2(BIN_W + 1);
  // ceil(BIN_W * log10(2)) decimal digits cover the full binary range
  localparam int BCD_NEED   = (BIN_W * 30103 + 99999) / 100000;
  localparam int BCD_DIGITS = (BCD_NEED > N_DIGITS) ? BCD_NEED : N_DIGITS;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] OVF_LIMIT = pow10(N_DIGITS);

  // One double-dabble iteration: +3 on nibbles >= 5, then shift in a bit
  function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] v,
                                                   input logic in_bit);
    logic [BCD_W-1:0] r;
    r = v;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
    end
    return {r[BCD_W-2:0], in_bit};
  endfunction

  // Active-low g..a pattern; anything outside 0..9 is blank
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t                  state_q;
  logic                    busy_q;
  logic [BIN_W-1:0]        bin_sr_q;
  logic [BIN_W-1:0]        last_q;
  logic                    ovf_work_q;
  logic [BCD_W-1:0]        bcd_q;
  logic [SH_W-1:0]         sh_cnt_q;
  logic [4*N_DIGITS-1:0]   disp_bcd_q;
  logic                    disp_ovf_q;

  logic [CNT_W-1:0]        tick_q, tick_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [7:0]              seg_q, seg_d;
  logic [N_DIGITS-1:0]     seg_comm_q, seg_comm_d;
  logic [3:0]              nib;

  // Conversion FSM: detect a new value, run BIN_W dabble steps, commit result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      bin_sr_q   <= '0;
      last_q     <= '0;
      ovf_work_q <= 1'b0;
      bcd_q      <= '0;
      sh_cnt_q   <= '0;
      disp_bcd_q <= '0;
      disp_ovf_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bin != last_q) begin
            bin_sr_q   <= bin;
            last_q     <= bin;
            ovf_work_q <= (64'(bin) >= OVF_LIMIT);
            bcd_q      <= '0;
            sh_cnt_q   <= '0;
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q    <= dabble_step(bcd_q, bin_sr_q[BIN_W-1]);
          bin_sr_q <= bin_sr_q << 1;
          sh_cnt_q <= sh_cnt_q + SH_W'(1);
          if (sh_cnt_q == SH_W'(BIN_W - 1)) state_q <= LOAD;
        end
        LOAD: begin
          // Digits and overflow flag change in the same edge so no mix is visible
          disp_bcd_q <= bcd_q[4*N_DIGITS-1:0];
          disp_ovf_q <= ovf_work_q;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Scan timebase: tick every DIV clocks advances the digit index
  always_comb begin
    tick_d = tick_q + CNT_W'(1);
    idx_d  = idx_q;
    if (tick_q == CNT_W'(DIV - 1)) begin
      tick_d = '0;
      idx_d  = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Segment/common encoding for the currently indexed digit
  always_comb begin
    seg_d      = 8'hFF;
    nib        = disp_bcd_q[4*idx_q +: 4];
    seg_d[7]   = ~dp[idx_q];
    seg_d[6:0] = disp_ovf_q ? 7'h3F : seg_decode(nib);
`ifdef FND_LZB_EN
    // Blank digits above the most-significant non-zero digit; digit 0 always shows
    if (!disp_ovf_q && (idx_q != '0) && ((disp_bcd_q >> (4*idx_q)) == '0))
      seg_d[6:0] = 7'h7F;
`else
`endif
    seg_comm_d = ~(N_DIGITS'(1) << idx_q);
  end

  // Scan registers: seg and seg_comm update together from one index
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q     <= '0;
      idx_q      <= '0;
      seg_q      <= 8'hFF;
      seg_comm_q <= '1;
    end else begin
      tick_q     <= tick_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      seg_comm_q <= seg_comm_d;
    end
  end

  assign seg      = seg_q;
  assign seg_comm = seg_comm_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller (N_DIGITS=4, BIN_W=14, DIV=4).
// Table of {bin, dp, per-digit expected seg} plus hand sequences for
// reset behaviour, mid-conversion input change and reset during SHIFT.
module tb_fnd_scan_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] bin;
  logic [3:0]  dp;
  logic [7:0]  seg;
  logic [3:0]  seg_comm;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fnd_scan_controller #(
    .N_DIGITS(4),
    .BIN_W(14),
    .CLK_HZ(1000),
    .SCAN_HZ(250)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bin(bin),
    .dp(dp),
    .seg(seg),
    .seg_comm(seg_comm),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [13:0]     bin;
    logic [3:0]      dp;
    logic [3:0][7:0] seg_exp;   // [d] = expected seg on digit d
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int comm_idx(input logic [3:0] c);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) begin
      m = 4'b1 << i;
      if (c == ~m) return i;
    end
    return -1;
  endfunction

  // Counts busy-high samples starting on the next cycle; optional bin change
  task automatic busy_window(input string name, input int change_at,
                             input logic [13:0] new_bin, output int len);
    len = 0;
    @(negedge clk);
    while (busy === 1'b1 && len < 100) begin
      len++;
      if (len == change_at) bin = new_bin;
      @(negedge clk);
    end
    if (len >= 100) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  // Waits for each digit to be scanned and compares its segment pattern
  task automatic scan_check(input string name, input logic [3:0][7:0] exp);
    int n;
    logic [3:0] m;
    for (int d = 0; d < 4; d++) begin
      m = 4'b1 << d;
      n = 0;
      while (seg_comm !== ~m && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (n >= 40) chk($sformatf("%s_comm%0d_timeout", name, d), 32'd1, 32'd0);
      else chk($sformatf("%s_d%0d", name, d), {24'd0, seg}, {24'd0, exp[d]});
    end
  endtask

  initial begin
    int len, bad, ix;
    logic [3:0][7:0] pat1234, pat5678, pat4321;
    logic [3:0] m;
    pat1234 = {8'hF9, 8'hA4, 8'hB0, 8'h99};
    pat5678 = {8'h92, 8'h82, 8'hF8, 8'h80};
    pat4321 = {8'h99, 8'hB0, 8'hA4, 8'hF9};

    vecs[0] = '{bin: 14'd1234,  dp: 4'b0000, seg_exp: {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[1] = '{bin: 14'd10000, dp: 4'b0000, seg_exp: {8'hBF, 8'hBF, 8'hBF, 8'hBF}};
    vecs[2] = '{bin: 14'd9999,  dp: 4'b0000, seg_exp: {8'h90, 8'h90, 8'h90, 8'h90}};
    vecs[3] = '{bin: 14'd1234,  dp: 4'b0100, seg_exp: {8'hF9, 8'h24, 8'hB0, 8'h99}};
`ifdef FND_LZB_EN
    vecs[4] = '{bin: 14'd7,     dp: 4'b0000, seg_exp: {8'hFF, 8'hFF, 8'hFF, 8'hF8}};
    vecs[5] = '{bin: 14'd0,     dp: 4'b0000, seg_exp: {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[9] = '{bin: 14'd9,     dp: 4'b0101, seg_exp: {8'hFF, 8'h7F, 8'hFF, 8'h10}};
`else
    vecs[4] = '{bin: 14'd7,     dp: 4'b0000, seg_exp: {8'hC0, 8'hC0, 8'hC0, 8'hF8}};
    vecs[5] = '{bin: 14'd0,     dp: 4'b0000, seg_exp: {8'hC0, 8'hC0, 8'hC0, 8'hC0}};
    vecs[9] = '{bin: 14'd9,     dp: 4'b0101, seg_exp: {8'hC0, 8'h40, 8'hC0, 8'h10}};
`endif
    vecs[6] = '{bin: 14'd16383, dp: 4'b1001, seg_exp: {8'h3F, 8'hBF, 8'hBF, 8'h3F}};
    vecs[7] = '{bin: 14'd5060,  dp: 4'b1111, seg_exp: {8'h12, 8'h40, 8'h02, 8'h40}};
    vecs[8] = '{bin: 14'd1000,  dp: 4'b0000, seg_exp: {8'hF9, 8'hC0, 8'hC0, 8'hC0}};

    // Reset held for three cycles with bin=0
    reset = 1'b1;
    bin   = '0;
    dp    = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_seg", {24'd0, seg}, 32'hFF);
      chk("rst_comm", {28'd0, seg_comm}, 32'hF);
      chk("rst_busy", {31'd0, busy}, 32'd0);
    end
    reset = 1'b0;
    bad = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      m = 4'b1 << ((k - 1) / 4);
      chk($sformatf("post_rst_comm_%0d", k), {28'd0, seg_comm}, {28'd0, ~m});
      if (seg !== 8'hC0 || busy !== 1'b0) bad++;
    end
    chk("post_rst_seg_busy_bad", bad, 32'd0);

    // Table-driven conversions
    for (int v = 0; v < 10; v++) begin
      dp  = vecs[v].dp;
      bin = vecs[v].bin;
      busy_window($sformatf("v%0d", v), 0, '0, len);
      chk($sformatf("v%0d_busy_len", v), len, 32'd15);
      @(negedge clk);
      scan_check($sformatf("v%0d", v), vecs[v].seg_exp);
    end

    // Unchanged input must not restart a conversion
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (busy !== 1'b0) bad++;
    end
    chk("same_bin_no_busy", bad, 32'd0);

    // Input changes during SHIFT: old result first, then second conversion
    dp  = '0;
    bin = 14'd1234;
    busy_window("chg1", 5, 14'd5678, len);
    chk("chg_busy1_len", len, 32'd15);
    len = 0;
    bad = 0;
    @(negedge clk);
    while (busy === 1'b1 && len < 100) begin
      len++;
      ix = comm_idx(seg_comm);
      if (ix < 0 || seg !== pat1234[ix]) bad++;
      @(negedge clk);
    end
    chk("chg_busy2_len", len, 32'd15);
    chk("chg_old_digits_bad", bad, 32'd0);
    @(negedge clk);
    scan_check("chg_new", pat5678);

    // Reset during SHIFT cycle 7 aborts, then 4321 converts again
    bin = 14'd4321;
    for (int k = 0; k < 7; k++) @(negedge clk);
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_seg", {24'd0, seg}, 32'hFF);
    chk("abort_comm", {28'd0, seg_comm}, 32'hF);
    reset = 1'b0;
    len = 0;
    bad = 0;
    @(negedge clk);
    while (busy === 1'b1 && len < 100) begin
      len++;
      if (seg !== 8'hC0) bad++;
      @(negedge clk);
    end
    chk("abort_restart_len", len, 32'd15);
    chk("abort_zero_display_bad", bad, 32'd0);
    @(negedge clk);
    scan_check("abort_4321", pat4321);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
